pipe_stage_regs: RTL and testbench
==================================

# pipe_stage_regs

Pipeline register block that consumes the stall/jump decisions of the hazard unit and applies them to the PC, IF/ID, ID/EX and EX/MEM registers of the 5-stage core. It holds the fetch side on a data hazard, inserts bubbles into Execute, and flushes the younger stages on a jump. It also returns `rd_E`, `rd_M` and `mem_command_M` to the hazard unit, closing the loop.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `NOP_INSTR`, 32'h0000_0013, instruction word injected into IF/ID on flush (`addi x0,x0,0`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wb_pc_f_hazard`  in  1  data hazard from hazard unit; stall request.
- `jump`  in  1  taken jump/branch resolved in Decode.
- `jump_target`  in  XLEN  next PC when `jump`=1.
- `imem_rdata`  in  32  instruction fetched at `pc_F`.
- `rd_D`, `rs1_D`, `rs2_D`  in  5 each  decoded register fields.
- `mem_command_D`  in  2  decoded memory command (0 = none).
- `reg_write_D`  in  1  decoded register-write enable.
- `pc_F`  out  XLEN  fetch PC (to imem).
- `instr_D`, `pc_D`, `valid_D`  out  32/XLEN/1  IF/ID register.
- `rd_E`, `rs1_E`, `rs2_E`, `mem_command_E`, `reg_write_E`, `valid_E`  out  ID/EX register.
- `rd_M`, `mem_command_M`, `reg_write_M`, `valid_M`  out  EX/MEM register.
- `stall_cnt`, `flush_cnt`  out  32 each  present only with `PIPE_PERF_CNT_EN`.

## Operation
Priority per cycle: `rst` > `jump` > `wb_pc_f_hazard` > advance.
- PC: jump → `jump_target`; hazard → hold; else `pc_F + 4` (mod 2^XLEN, wraps silently).
- IF/ID: jump → `instr_D`=NOP_INSTR, `valid_D`=0, `pc_D` hold; hazard → hold all; else load `imem_rdata`, `pc_F`, `valid_D`=1.
- ID/EX: jump or hazard → bubble: `rd_E`=`rs1_E`=`rs2_E`=0, `mem_command_E`=0, `reg_write_E`=0, `valid_E`=0; else load D fields, `valid_E`=`valid_D`. A D-stage entry with `valid_D`=0 always enters Execute as a bubble (fields forced to 0).
- EX/MEM: always advances from ID/EX; never stalled or flushed.
- Bubble encoding guarantees `rd_E`=0 / `rd_M`=0 for invalid slots, so the hazard unit sees no false dependency.
- Jump and hazard together: jump wins; PC redirects, IF/ID flushed, ID/EX bubbled. Hazard in the following cycle is re-evaluated on the new IF/ID contents.

## Timing
- All registers update on rising `clk`; no combinational path from inputs to outputs.
- Reset values: `pc_F`=RESET_PC; `instr_D`=NOP_INSTR, `pc_D`=0, `valid_D`=0; all ID/EX and EX/MEM outputs 0; counters 0.
- Reset asserted mid-operation discards all in-flight state at the next edge; the first fetch after `rst` falls is at RESET_PC and `valid_D`=1 one cycle later.
- Hazard of N consecutive cycles: PC and IF/ID hold N cycles; N bubbles enter Execute; the held instruction reaches Execute on cycle N+1.
- Jump: `pc_F`=`jump_target` next cycle; target instruction in `instr_D` one cycle after that (2-cycle penalty counting the Execute bubble).

## Configuration
- `PIPE_PERF_CNT_EN` defined: `stall_cnt` increments each cycle with `wb_pc_f_hazard`=1 and `jump`=0; `flush_cnt` increments each cycle with `jump`=1; both saturate at 32'hFFFF_FFFF and clear on `rst`.
- Undefined: counter ports and logic are absent; all other behaviour is identical.

## Test plan
- Reset: hold `rst` 3 cycles → `pc_F`=0, `instr_D`=32'h13, `valid_D`=0, `rd_E`=`rd_M`=0; release → `pc_F` sequence 0, 4, 8.
- Single hazard: `rd_D`=5, hazard=1 for 2 cycles at `pc_F`=0x10 → `pc_F` stays 0x10, `instr_D` stable, `valid_E`=0 for 2 cycles, then `pc_F`=0x14.
- Jump: `jump`=1, `jump_target`=0x100 at `pc_F`=0x20 → next `pc_F`=0x100, `instr_D`=32'h13, `valid_D`=0, `valid_E`=0; next cycle `pc_D`=0x100.
- Simultaneous jump+hazard → identical to jump alone; `stall_cnt` unchanged, `flush_cnt` +1 (with macro).
- PC wrap: `jump_target`=32'hFFFF_FFFC, no hazard → `pc_F` goes 0xFFFF_FFFC then 0x0000_0000.
- Reset mid-stall: `rst` asserted while hazard=1 → all outputs return to reset values next edge; counters (with macro) read 0.

Source files
------------

// File: rtl/pipe_stage_regs.sv
// -----------------------------------------------------------------------------
// pipe_stage_regs
//   PC, IF/ID, ID/EX and EX/MEM registers of the 5-stage core. Applies the
//   hazard unit's stall request and the Decode-stage jump decision:
//     rst > jump (flush) > wb_pc_f_hazard (stall) > advance.
//   Execute bubbles carry all-zero fields so rd_E/rd_M never alias x1..x31.
//
//   Optional build macro: PIPE_PERF_CNT_EN
//     defined   -> stall_cnt / flush_cnt saturating event counters exist.
//     undefined -> counter ports and logic are absent.
//
//   Reset is synchronous, active-high, sampled on the rising edge of clk.
// -----------------------------------------------------------------------------
module pipe_stage_regs #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,

  // Hazard unit / Decode decisions
  input  logic            wb_pc_f_hazard,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,

  // Fetch data and decoded fields of the instruction held in IF/ID
  input  logic [31:0]     imem_rdata,
  input  logic [4:0]      rd_D,
  input  logic [4:0]      rs1_D,
  input  logic [4:0]      rs2_D,
  input  logic [1:0]      mem_command_D,
  input  logic            reg_write_D,

  // Fetch
  output logic [XLEN-1:0] pc_F,

  // IF/ID
  output logic [31:0]     instr_D,
  output logic [XLEN-1:0] pc_D,
  output logic            valid_D,

  // ID/EX
  output logic [4:0]      rd_E,
  output logic [4:0]      rs1_E,
  output logic [4:0]      rs2_E,
  output logic [1:0]      mem_command_E,
  output logic            reg_write_E,
  output logic            valid_E,

  // EX/MEM
  output logic [4:0]      rd_M,
  output logic [1:0]      mem_command_M,
  output logic            reg_write_M,
  output logic            valid_M
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // Types
  // ---------------------------------------------------------------------------
  // One pipeline-wide action per cycle; encodes the priority chain once so the
  // per-register logic below only has to look at a single selector.
  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_STALL   = 2'd1,
    ACT_FLUSH   = 2'd2,
    ACT_RESET   = 2'd3
  } pipe_act_e;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [1:0] mem_command;
    logic       reg_write;
    logic       valid;
  } id_ex_t;

  typedef struct packed {
    logic [4:0] rd;
    logic [1:0] mem_command;
    logic       reg_write;
    logic       valid;
  } ex_mem_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // ---------------------------------------------------------------------------
  // Registers and next-state wires
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] r_pc_f;
  logic [31:0]     r_instr_d;
  logic [XLEN-1:0] r_pc_d;
  logic            r_valid_d;
  id_ex_t          r_id_ex;
  ex_mem_t         r_ex_mem;

  pipe_act_e       w_act;
  logic [XLEN-1:0] w_pc_next;
  logic [31:0]     w_instr_d_next;
  logic [XLEN-1:0] w_pc_d_next;
  logic            w_valid_d_next;
  id_ex_t          w_id_ex_next;
  ex_mem_t         w_ex_mem_next;

  // Resolve the per-cycle action from reset, jump and hazard in priority order.
  // NOTE: every always_comb output gets a default on entry; a path that leaves
  // a variable unassigned would otherwise infer a latch.
  always_comb begin
    w_act = ACT_ADVANCE;
    if (rst) begin
      w_act = ACT_RESET;
    end else if (jump) begin
      w_act = ACT_FLUSH;
    end else if (wb_pc_f_hazard) begin
      w_act = ACT_STALL;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch PC
  // ---------------------------------------------------------------------------
  // Next fetch address: redirect on jump, hold on stall, else sequential (wraps).
  always_comb begin
    w_pc_next = r_pc_f;
    case (w_act)
      ACT_RESET:   w_pc_next = RESET_PC;
      ACT_FLUSH:   w_pc_next = jump_target;
      ACT_STALL:   w_pc_next = r_pc_f;
      ACT_ADVANCE: w_pc_next = r_pc_f + PC_STEP;
      default:     w_pc_next = r_pc_f;
    endcase
  end

  // PC register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    r_pc_f <= w_pc_next;
  end

  // ---------------------------------------------------------------------------
  // IF/ID
  // ---------------------------------------------------------------------------
  // Flush replaces the fetched word with a NOP but keeps pc_D; stall holds all.
  always_comb begin
    w_instr_d_next = r_instr_d;
    w_pc_d_next    = r_pc_d;
    w_valid_d_next = r_valid_d;
    case (w_act)
      ACT_RESET: begin
        w_instr_d_next = NOP_INSTR;
        w_pc_d_next    = '0;
        w_valid_d_next = 1'b0;
      end
      ACT_FLUSH: begin
        w_instr_d_next = NOP_INSTR;
        w_valid_d_next = 1'b0;
      end
      ACT_ADVANCE: begin
        w_instr_d_next = imem_rdata;
        w_pc_d_next    = r_pc_f;
        w_valid_d_next = 1'b1;
      end
      default: ; // ACT_STALL: hold
    endcase
  end

  // IF/ID register.
  always_ff @(posedge clk) begin
    r_instr_d <= w_instr_d_next;
    r_pc_d    <= w_pc_d_next;
    r_valid_d <= w_valid_d_next;
  end

  // ---------------------------------------------------------------------------
  // ID/EX
  // ---------------------------------------------------------------------------
  // Load Decode fields only when advancing a valid slot; anything else is an
  // all-zero bubble so downstream hazard checks never see a stale rd.
  always_comb begin
    w_id_ex_next = '0;
    if ((w_act == ACT_ADVANCE) && r_valid_d) begin
      w_id_ex_next.rd          = rd_D;
      w_id_ex_next.rs1         = rs1_D;
      w_id_ex_next.rs2         = rs2_D;
      w_id_ex_next.mem_command = mem_command_D;
      w_id_ex_next.reg_write   = reg_write_D;
      w_id_ex_next.valid       = 1'b1;
    end
  end

  // ID/EX register.
  always_ff @(posedge clk) begin
    r_id_ex <= w_id_ex_next;
  end

  // ---------------------------------------------------------------------------
  // EX/MEM
  // ---------------------------------------------------------------------------
  // Execute always drains into Memory; only reset clears it.
  always_comb begin
    w_ex_mem_next = '0;
    if (w_act != ACT_RESET) begin
      w_ex_mem_next.rd          = r_id_ex.rd;
      w_ex_mem_next.mem_command = r_id_ex.mem_command;
      w_ex_mem_next.reg_write   = r_id_ex.reg_write;
      w_ex_mem_next.valid       = r_id_ex.valid;
    end
  end

  // EX/MEM register.
  always_ff @(posedge clk) begin
    r_ex_mem <= w_ex_mem_next;
  end

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic        w_stall_evt;
  logic        w_flush_evt;

  // A stall only counts when it actually took effect (jump did not override it).
  assign w_stall_evt = (w_act == ACT_STALL);
  assign w_flush_evt = (w_act == ACT_FLUSH);

  // Saturating event counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_flush_evt && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

  // ---------------------------------------------------------------------------
  // Outputs (registered only; no input-to-output combinational path)
  // ---------------------------------------------------------------------------
  assign pc_F          = r_pc_f;
  assign instr_D       = r_instr_d;
  assign pc_D          = r_pc_d;
  assign valid_D       = r_valid_d;

  assign rd_E          = r_id_ex.rd;
  assign rs1_E         = r_id_ex.rs1;
  assign rs2_E         = r_id_ex.rs2;
  assign mem_command_E = r_id_ex.mem_command;
  assign reg_write_E   = r_id_ex.reg_write;
  assign valid_E       = r_id_ex.valid;

  assign rd_M          = r_ex_mem.rd;
  assign mem_command_M = r_ex_mem.mem_command;
  assign reg_write_M   = r_ex_mem.reg_write;
  assign valid_M       = r_ex_mem.valid;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_regs
//   Directed bench for pipe_stage_regs. A slot-level model of the pipeline
//   (what instruction occupies Fetch, Decode, Execute and Memory) is compared
//   against every output on each falling edge; literal checks at key points
//   pin both the DUT and the model. Counter checks exist when the design is
//   built with PIPE_PERF_CNT_EN.
// -----------------------------------------------------------------------------
module tb_pipe_stage_regs;

  logic        clk;
  logic        rst;
  logic        wb_pc_f_hazard;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_rdata;
  logic [4:0]  rd_D, rs1_D, rs2_D;
  logic [1:0]  mem_command_D;
  logic        reg_write_D;

  logic [31:0] pc_F;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic        valid_D;
  logic [4:0]  rd_E, rs1_E, rs2_E;
  logic [1:0]  mem_command_E;
  logic        reg_write_E, valid_E;
  logic [4:0]  rd_M;
  logic [1:0]  mem_command_M;
  logic        reg_write_M, valid_M;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipe_stage_regs dut (
    .clk            (clk),
    .rst            (rst),
    .wb_pc_f_hazard (wb_pc_f_hazard),
    .jump           (jump),
    .jump_target    (jump_target),
    .imem_rdata     (imem_rdata),
    .rd_D           (rd_D),
    .rs1_D          (rs1_D),
    .rs2_D          (rs2_D),
    .mem_command_D  (mem_command_D),
    .reg_write_D    (reg_write_D),
    .pc_F           (pc_F),
    .instr_D        (instr_D),
    .pc_D           (pc_D),
    .valid_D        (valid_D),
    .rd_E           (rd_E),
    .rs1_E          (rs1_E),
    .rs2_E          (rs2_E),
    .mem_command_E  (mem_command_E),
    .reg_write_E    (reg_write_E),
    .valid_E        (valid_E),
    .rd_M           (rd_M),
    .mem_command_M  (mem_command_M),
    .reg_write_M    (reg_write_M),
    .valid_M        (valid_M)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory stand-in: each word is derived from its address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h1234_5600;
  endfunction

  assign imem_rdata = imem(pc_F);

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Slot model: which instruction occupies each stage, cycle by cycle.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit         live;
    logic [4:0] rd, rs1, rs2;
    logic [1:0] mc;
    bit         rw;
  } exec_slot_t;

  logic [31:0] m_fetch_pc;
  logic [31:0] m_dec_word, m_dec_pc;
  bit          m_dec_live;
  exec_slot_t  m_ex, m_mem;
  longint      m_stalls, m_flushes;

  function automatic exec_slot_t empty_slot();
    exec_slot_t s;
    s.live = 0; s.rd = 0; s.rs1 = 0; s.rs2 = 0; s.mc = 0; s.rw = 0;
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_fetch_pc <= 32'h0;
      m_dec_word <= 32'h13;
      m_dec_pc   <= 32'h0;
      m_dec_live <= 1'b0;
      m_ex       <= empty_slot();
      m_mem      <= empty_slot();
      m_stalls   <= 0;
      m_flushes  <= 0;
    end else begin
      // Memory receives whatever Execute held.
      m_mem <= m_ex;
      // Execute receives the decoded instruction only when the front end moves
      // and Decode actually holds a live instruction.
      if (!jump && !wb_pc_f_hazard && m_dec_live) begin
        exec_slot_t s;
        s.live = 1; s.rd = rd_D; s.rs1 = rs1_D; s.rs2 = rs2_D;
        s.mc = mem_command_D; s.rw = reg_write_D;
        m_ex <= s;
      end else begin
        m_ex <= empty_slot();
      end
      if (jump) begin
        m_fetch_pc <= jump_target;
        m_dec_word <= 32'h13;
        m_dec_live <= 1'b0;
        m_flushes  <= m_flushes + 1;
      end else if (wb_pc_f_hazard) begin
        m_stalls   <= m_stalls + 1;
      end else begin
        m_fetch_pc <= m_fetch_pc + 32'd4;
        m_dec_word <= imem(m_fetch_pc);
        m_dec_pc   <= m_fetch_pc;
        m_dec_live <= 1'b1;
      end
    end
  end

  // Compare every output to the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc_F",          pc_F,          m_fetch_pc);
      check("instr_D",       instr_D,       m_dec_word);
      check("pc_D",          pc_D,          m_dec_pc);
      check("valid_D",       valid_D,       m_dec_live);
      check("rd_E",          rd_E,          m_ex.rd);
      check("rs1_E",         rs1_E,         m_ex.rs1);
      check("rs2_E",         rs2_E,         m_ex.rs2);
      check("mem_command_E", mem_command_E, m_ex.mc);
      check("reg_write_E",   reg_write_E,   m_ex.rw);
      check("valid_E",       valid_E,       m_ex.live);
      check("rd_M",          rd_M,          m_mem.rd);
      check("mem_command_M", mem_command_M, m_mem.mc);
      check("reg_write_M",   reg_write_M,   m_mem.rw);
      check("valid_M",       valid_M,       m_mem.live);
`ifdef PIPE_PERF_CNT_EN
      check("stall_cnt",     stall_cnt,     m_stalls);
      check("flush_cnt",     flush_cnt,     m_flushes);
`endif
    end
  end

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [4:0] rd, input logic [4:0] r1,
                            input logic [4:0] r2, input logic [1:0] mc, input logic rw);
    rd_D = rd; rs1_D = r1; rs2_D = r2; mem_command_D = mc; reg_write_D = rw;
  endtask

  // Mixed directed vectors: {hazard, jump, target, rd, rs1, rs2, mc, rw}
  typedef struct {
    bit          hz;
    bit          jp;
    logic [31:0] tgt;
    logic [4:0]  rd, r1, r2;
    logic [1:0]  mc;
    bit          rw;
  } vec_t;

  vec_t vecs[10];

  logic [31:0] held_instr;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] s_before, f_before;
`endif

  initial begin
    rst = 1'b1; wb_pc_f_hazard = 1'b0; jump = 1'b0; jump_target = 32'h0;
    set_fields(5'd0, 5'd0, 5'd0, 2'd0, 1'b0);

    vecs[0] = '{0, 0, 32'h0,   5'd7,  5'd1,  5'd2,  2'd1, 1};
    vecs[1] = '{0, 0, 32'h0,   5'd8,  5'd3,  5'd4,  2'd2, 0};
    vecs[2] = '{1, 0, 32'h0,   5'd9,  5'd5,  5'd6,  2'd0, 1};
    vecs[3] = '{0, 0, 32'h0,   5'd10, 5'd11, 5'd12, 2'd3, 1};
    vecs[4] = '{0, 1, 32'h400, 5'd13, 5'd14, 5'd15, 2'd1, 1};
    vecs[5] = '{1, 0, 32'h0,   5'd16, 5'd17, 5'd18, 2'd2, 0};
    vecs[6] = '{0, 0, 32'h0,   5'd19, 5'd20, 5'd21, 2'd0, 1};
    vecs[7] = '{0, 0, 32'h0,   5'd31, 5'd30, 5'd29, 2'd3, 1};
    vecs[8] = '{1, 1, 32'h800, 5'd22, 5'd23, 5'd24, 2'd1, 0};
    vecs[9] = '{0, 0, 32'h0,   5'd25, 5'd26, 5'd27, 2'd2, 1};

    // Reset held for 3 cycles
    step();
    chk_en = 1'b1;
    step();
    step();
    check("rst_pc_F",    pc_F,    32'h0);
    check("rst_instr_D", instr_D, 32'h13);
    check("rst_valid_D", valid_D, 1'b0);
    check("rst_rd_E",    rd_E,    5'd0);
    check("rst_rd_M",    rd_M,    5'd0);

    // Release: pc_F sequence 0, 4, 8
    rst = 1'b0;
    check("rel_pc0", pc_F, 32'h0);
    step();
    check("rel_pc4", pc_F, 32'h4);
    check("rel_valid_D", valid_D, 1'b1);
    check("rel_instr_D", instr_D, 32'h1234_5603);
    step();
    check("rel_pc8", pc_F, 32'h8);
    step();
    step();
    check("pre_hz_pc", pc_F, 32'h10);

    // Single hazard for 2 cycles at pc_F = 0x10
    set_fields(5'd5, 5'd1, 5'd2, 2'd1, 1'b1);
    wb_pc_f_hazard = 1'b1;
    held_instr = instr_D;
    for (int i = 0; i < 2; i++) begin
      step();
      check("hz_pc_hold",    pc_F,    32'h10);
      check("hz_instr_hold", instr_D, 32'h1234_560F);
      check("hz_bubble",     valid_E, 1'b0);
      check("hz_bubble_rd",  rd_E,    5'd0);
    end
    wb_pc_f_hazard = 1'b0;
    step();
    check("hz_pc_resume", pc_F,    32'h14);
    check("hz_held_to_E", rd_E,    5'd5);
    check("hz_valid_E",   valid_E, 1'b1);
    step();
    check("hz_rd_M", rd_M, 5'd5);
    step();
    check("pre_jmp_pc", pc_F, 32'h1C);
    step();

    // Jump at pc_F = 0x20
    check("jmp_at_pc", pc_F, 32'h20);
    jump = 1'b1; jump_target = 32'h100;
    step();
    jump = 1'b0;
    check("jmp_pc",      pc_F,    32'h100);
    check("jmp_instr_D", instr_D, 32'h13);
    check("jmp_valid_D", valid_D, 1'b0);
    check("jmp_valid_E", valid_E, 1'b0);
    step();
    check("jmp_pc_D",   pc_D,    32'h100);
    check("jmp_tgt_in", instr_D, 32'h1234_5703);
    check("jmp_bub_E",  valid_E, 1'b0);

    // Simultaneous jump + hazard behaves as jump alone
`ifdef PIPE_PERF_CNT_EN
    s_before = stall_cnt; f_before = flush_cnt;
`endif
    jump = 1'b1; wb_pc_f_hazard = 1'b1; jump_target = 32'h200;
    step();
    jump = 1'b0; wb_pc_f_hazard = 1'b0;
    check("jh_pc",      pc_F,    32'h200);
    check("jh_valid_D", valid_D, 1'b0);
    check("jh_valid_E", valid_E, 1'b0);
`ifdef PIPE_PERF_CNT_EN
    check("jh_stall_cnt", stall_cnt, s_before);
    check("jh_flush_cnt", flush_cnt, f_before + 32'd1);
`endif
    step();
    check("jh_pc_D", pc_D, 32'h200);

    // PC wrap
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    step();
    jump = 1'b0;
    check("wrap_pc_top", pc_F, 32'hFFFF_FFFC);
    step();
    check("wrap_pc_zero", pc_F, 32'h0);
    step();
    check("wrap_pc_D", pc_D, 32'h0);

    // Mixed directed vectors, checked by the compare process
    foreach (vecs[i]) begin
      wb_pc_f_hazard = vecs[i].hz;
      jump           = vecs[i].jp;
      jump_target    = vecs[i].tgt;
      set_fields(vecs[i].rd, vecs[i].r1, vecs[i].r2, vecs[i].mc, vecs[i].rw);
      step();
    end
    jump = 1'b0; wb_pc_f_hazard = 1'b0;
    step();

    // Reset asserted mid-stall
    wb_pc_f_hazard = 1'b1;
    set_fields(5'd12, 5'd3, 5'd4, 2'd2, 1'b1);
    step();
    rst = 1'b1;
    step();
    check("rs_pc_F",    pc_F,    32'h0);
    check("rs_instr_D", instr_D, 32'h13);
    check("rs_pc_D",    pc_D,    32'h0);
    check("rs_valid_D", valid_D, 1'b0);
    check("rs_valid_E", valid_E, 1'b0);
    check("rs_rd_M",    rd_M,    5'd0);
    check("rs_valid_M", valid_M, 1'b0);
`ifdef PIPE_PERF_CNT_EN
    check("rs_stall_cnt", stall_cnt, 32'h0);
    check("rs_flush_cnt", flush_cnt, 32'h0);
`endif
    rst = 1'b0; wb_pc_f_hazard = 1'b0;
    step();
    check("rs_fetch_pc", pc_F,    32'h4);
    check("rs_valid_D1", valid_D, 1'b1);
    check("rs_pc_D0",    pc_D,    32'h0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
